// File: rtl/first_countdown.sv
// Loadable down-counter with sticky underflow flag, one-cycle underflow strobe and RUN indicator.
// Optional build macro AUTO_RELOAD_EN: on underflow, reload the last loaded value and keep running.
module first_countdown #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] counter_out,
   output logic             underflow_out,
   output logic             zero_pulse,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             underflow_q, underflow_d;
   logic             pulse_q, pulse_d;
   logic             busy_q, busy_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         reload_q    <= '0;
         underflow_q <= 1'b0;
         pulse_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         reload_q    <= reload_d;
         underflow_q <= underflow_d;
         pulse_q     <= pulse_d;
         busy_q      <= busy_d;
      end
   end

   // Load overrides everything, including an underflow that would happen on the same edge.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      reload_d    = reload_q;
      underflow_d = underflow_q;
      pulse_d     = 1'b0;
      if (load) begin
         count_d     = load_value;
         reload_d    = load_value;
         underflow_d = 1'b0;
         state_d     = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (enable) begin
                  if (count_q != '0) begin
                     count_d = count_q - WIDTH'(1);
                  end else begin
                     underflow_d = 1'b1;
                     pulse_d     = 1'b1;
`ifdef AUTO_RELOAD_EN
                     count_d     = reload_q;
                     state_d     = RUN;
`else
                     count_d     = '1;
                     state_d     = DONE;
`endif
                  end
               end
            end
            IDLE:    state_d = IDLE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == RUN);
   end

   assign counter_out   = count_q;
   assign underflow_out = underflow_q;
   assign zero_pulse    = pulse_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_first_countdown.sv
// Scoreboard bench for first_countdown: directed scenarios followed by random stimulus,
// with expected outputs from a behavioural model queued and checked by a separate monitor.
module tb_first_countdown;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk;
   logic         reset;
   logic         enable;
   logic         load;
   logic [W-1:0] load_value;
   logic [W-1:0] counter_out;
   logic         underflow_out;
   logic         zero_pulse;
   logic         busy;

   typedef struct {
      int cnt;
      int uf;
      int zp;
      int bsy;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   // Behavioural model: an integer count, a mode and the remembered start value.
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   int m_cnt    = 0;
   int m_reload = 0;
   int m_mode   = M_IDLE;
   int m_uf     = 0;
   int m_zp     = 0;

   first_countdown #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .load         (load),
      .load_value   (load_value),
      .counter_out  (counter_out),
      .underflow_out(underflow_out),
      .zero_pulse   (zero_pulse),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input bit r, input bit ld, input bit en, input int lv);
      exp_t e;
      @(negedge clk);
      reset      = r;
      load       = ld;
      enable     = en;
      load_value = W'(lv);
      if (r) begin
         m_cnt = 0; m_reload = 0; m_mode = M_IDLE; m_uf = 0; m_zp = 0;
      end else if (ld) begin
         m_cnt = lv % MOD; m_reload = lv % MOD; m_mode = M_RUN; m_uf = 0; m_zp = 0;
      end else if (m_mode == M_RUN && en) begin
         if (m_cnt == 0) begin
            m_uf = 1;
            m_zp = 1;
`ifdef AUTO_RELOAD_EN
            m_cnt = m_reload;
`else
            m_cnt  = MOD - 1;
            m_mode = M_DONE;
`endif
         end else begin
            m_cnt = (m_cnt + MOD - 1) % MOD;
            m_zp  = 0;
         end
      end else begin
         m_zp = 0;
      end
      e.cnt = m_cnt;
      e.uf  = m_uf;
      e.zp  = m_zp;
      e.bsy = (m_mode == M_RUN) ? 1 : 0;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle, one queued expectation per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("counter_out",   int'(counter_out),   e.cnt);
            checkOutput("underflow_out", int'(underflow_out), e.uf);
            checkOutput("zero_pulse",    int'(zero_pulse),    e.zp);
            checkOutput("busy",          int'(busy),          e.bsy);
         end
      end
   end

   initial begin
      reset      = 1'b1;
      load       = 1'b0;
      enable     = 1'b0;
      load_value = '0;

      // Reset wins over load and enable, then enable alone in IDLE does nothing.
      applyStimulus(1, 1, 1, 7);
      applyStimulus(1, 1, 1, 7);
      repeat (3) applyStimulus(0, 0, 1, 0);

      // Count 3 down through underflow, then stay in DONE.
      applyStimulus(0, 1, 0, 3);
      repeat (7) applyStimulus(0, 0, 1, 0);

      // Reload from DONE and count with gaps.
      applyStimulus(0, 1, 0, 5);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0);

      // Load beats an underflow on the same edge.
      applyStimulus(0, 1, 0, 1);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 1, 9);
      applyStimulus(0, 0, 0, 0);

      // Reset mid-count.
      applyStimulus(0, 1, 0, 2);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);

      // Zero load underflows on the first enabled edge; then a continuous run.
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 0, 2);
      repeat (8) applyStimulus(0, 0, 1, 0);

      for (int i = 0; i < 3000; i++) begin
         int lv;
         lv = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, MOD - 1);
         applyStimulus($urandom_range(0, 59) == 0,
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 3) != 0,
                       lv);
      end

      // Give the monitor a bounded window to drain the scoreboard.
      for (int i = 0; i < 5 && sb.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
